// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes and the multiplier sequencer state type.
package cpu_pkg;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add MUL sequencer that borrows the shared EX-stage ALU one bit per cycle.
// Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse with product valid.
module alu_mul_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] ex_alu_a,
  input  logic [WIDTH-1:0] ex_alu_b,
  input  logic [2:0]       ex_alu_ctrl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output mul_state_t       state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;

  mul_state_t       state, state_n;
  logic [WIDTH-1:0] m, q, acc;
  logic [CW-1:0]    count;
  logic             done_q;
  logic             accept, zero_b, finish;

  assign accept = start && !flush;
  assign zero_b = (EARLY_EXIT != 0) && (op_b == '0);
  assign finish = (count == CW'(WIDTH - 1)) ||
                  ((EARLY_EXIT != 0) && ((q >> 1) == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    stall    = 1'b0;
    alu_a    = ex_alu_a;
    alu_b    = ex_alu_b;
    alu_ctrl = ex_alu_ctrl;
    case (state)
      IDLE: begin
        stall = accept;
        if (accept) state_n = zero_b ? DONE : RUN;
      end
      RUN: begin
        stall    = !flush;
        alu_a    = m;
        alu_b    = acc;
        alu_ctrl = q[0] ? ALU_ADD : ALU_PASS_B;
        if (flush)       state_n = IDLE;
        else if (finish) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_n == DONE);
      if (state == IDLE && accept) begin
        m     <= op_a;
        q     <= op_b;
        acc   <= '0;
        count <= '0;
        if (zero_b) product <= '0;
      end else if (state == RUN && !flush) begin
        acc   <= alu_result;
        m     <= m << 1;
        q     <= q >> 1;
        count <= count + 1'b1;
        if (finish) product <= alu_result;
      end
    end
  end

  // A flush landing in the DONE cycle kills the pulse so EX never retires the aborted MUL.
  assign done      = done_q && !flush;
  assign state_dbg = state;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural model of the shared ALU.
module tb_alu_mul_seq;
  import cpu_pkg::*;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, flush;
  logic [W-1:0]  op_a, op_b, ex_alu_a, ex_alu_b;
  logic [2:0]    ex_alu_ctrl;
  logic [W-1:0]  alu_a, alu_b, alu_result, product;
  logic [2:0]    alu_ctrl;
  logic          stall, done;
  mul_state_t    state_dbg;

  int vectors = 0;
  int miscompares = 0;
  int c;
  int seen;

  alu_mul_seq #(.WIDTH(W), .EARLY_EXIT(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b),
    .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_alu_ctrl(ex_alu_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .stall(stall), .done(done), .product(product), .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Shared ALU model
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_PASS_B: alu_result = alu_b;
      ALU_ADD:    alu_result = alu_a + alu_b;
      ALU_SUB:    alu_result = alu_a - alu_b;
      ALU_AND:    alu_result = alu_a & alu_b;
      ALU_OR:     alu_result = alu_a | alu_b;
      ALU_XOR:    alu_result = alu_a ^ alu_b;
      default:    alu_result = '0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Steps until done or the budget expires; returns cycles since the start cycle.
  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (!done && cyc < budget) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; flush = 1'b0;
    op_a = '0; op_b = '0; ex_alu_a = '0; ex_alu_b = '0; ex_alu_ctrl = 3'b000;
    repeat (2) step();
    check("reset_state", W'(state_dbg), W'(IDLE));
    check("reset_product", product, 64'd0);
    check("reset_done", W'(done), 64'd0);
    reset_n = 1'b1;
    step();

    // Passthrough
    ex_alu_ctrl = 3'b011; ex_alu_a = 64'd9; ex_alu_b = 64'd4;
    #1;
    check("pass_a", alu_a, 64'd9);
    check("pass_b", alu_b, 64'd4);
    check("pass_ctrl", W'(alu_ctrl), 64'd3);
    check("pass_stall", W'(stall), 64'd0);

    // Basic 3*5
    start = 1'b1; op_a = 64'd3; op_b = 64'd5;
    #1;
    check("basic_c0_stall", W'(stall), 64'd1);
    check("basic_c0_ctrl", W'(alu_ctrl), 64'd3);
    step(); start = 1'b0; #1;
    check("basic_c1_ctrl", W'(alu_ctrl), 64'd2);
    check("basic_c1_a", alu_a, 64'd3);
    check("basic_c1_stall", W'(stall), 64'd1);
    step();
    check("basic_c2_ctrl", W'(alu_ctrl), 64'd0);
    check("basic_c2_stall", W'(stall), 64'd1);
    step();
    check("basic_c3_ctrl", W'(alu_ctrl), 64'd2);
    check("basic_c3_stall", W'(stall), 64'd1);
    step();
    check("basic_c4_done", W'(done), 64'd1);
    check("basic_c4_product", product, 64'd15);
    check("basic_c4_stall", W'(stall), 64'd0);
    check("basic_c4_alu_a", alu_a, 64'd9);
    step();
    check("basic_c5_done", W'(done), 64'd0);
    check("basic_c5_product", product, 64'd15);

    // op_b == 0 exits immediately
    start = 1'b1; op_a = 64'd123; op_b = 64'd0;
    step(); start = 1'b0; #1;
    check("zero_c1_done", W'(done), 64'd1);
    check("zero_c1_product", product, 64'd0);
    step();

    // Full width all ones
    start = 1'b1; op_a = '1; op_b = '1;
    step(); start = 1'b0;
    wait_done(200, c);
    check("full_latency", W'(c), 64'd65);
    check("full_product", product, 64'd1);
    step();

    // Flush mid-run
    start = 1'b1; op_a = 64'd7; op_b = 64'h8000_0000_0000_0000;
    step(); start = 1'b0;
    repeat (9) step();
    flush = 1'b1; #1;
    check("flush_c10_stall", W'(stall), 64'd0);
    check("flush_c10_done", W'(done), 64'd0);
    step();
    check("flush_c11_state", W'(state_dbg), W'(IDLE));
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (done) seen++;
      step();
    end
    check("flush_no_done", W'(seen), 64'd0);
    check("flush_product_kept", product, 64'd1);

    // Reset mid-run
    start = 1'b1; op_a = '1; op_b = '1;
    step(); start = 1'b0;
    repeat (19) step();
    check("rst_pre_stall", W'(stall), 64'd1);
    reset_n = 1'b0; #1;
    check("rst_stall", W'(stall), 64'd0);
    check("rst_done", W'(done), 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_state", W'(state_dbg), W'(IDLE));
    step();
    reset_n = 1'b1;
    step();

    // 6*7 after reset
    start = 1'b1; op_a = 64'd6; op_b = 64'd7;
    step(); start = 1'b0;
    wait_done(200, c);
    check("mul42_latency", W'(c), 64'd4);
    check("mul42_product", product, 64'd42);
    step();

    // start held high through RUN and DONE
    start = 1'b1; op_a = 64'd2; op_b = 64'd3;
    step();
    op_a = 64'd100; op_b = 64'd100;
    wait_done(200, c);
    check("hold_latency", W'(c), 64'd3);
    check("hold_product", product, 64'd6);
    step();
    check("hold_back_idle", W'(state_dbg), W'(IDLE));
    start = 1'b0; #1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || stall) seen++;
      step();
    end
    check("hold_single_op", W'(seen), 64'd0);

    // start + flush in IDLE
    start = 1'b1; flush = 1'b1; op_a = 64'd5; op_b = 64'd9;
    #1;
    check("sf_stall", W'(stall), 64'd0);
    step();
    check("sf_state", W'(state_dbg), W'(IDLE));
    start = 1'b0; flush = 1'b0;
    step();
    check("sf_done", W'(done), 64'd0);
    check("sf_product", product, 64'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
